// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte
// through the open-drain PS2_CLK/PS2_DAT pins and waits for the ACK.
// Ports:
//   clk50, reset        : 50 MHz clock, async active-high reset
//   tx_data/valid/ready : command byte handshake (ready only in IDLE)
//   ps2_clk_in/dat_in   : raw pin levels
//   ps2_clk_oe/dat_oe   : 1 = pull pin low, 0 = release
//   rx_inhibit          : tells the receiver to ignore the lines
//   tx_done/tx_error    : one-cycle completion / abort pulses
//   err_code            : 01 timeout, 10 no ACK (held until next error)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 6000,
  parameter int TIMEOUT_CYCLES   = 750000,
  parameter int IDLE_WAIT_CYCLES = 2500
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam int CNT_MAX =
    (INHIBIT_CYCLES > IDLE_WAIT_CYCLES) ?
    INHIBIT_CYCLES : IDLE_WAIT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDL_LAST =
    CNT_W'(IDLE_WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [3:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;

  logic r_clk_meta;
  logic r_clk_s;
  logic r_clk_prev;
  logic r_dat_meta;
  logic r_dat_s;

  logic w_fe;
  logic w_timed;
  logic w_tmo_hit;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_s    <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_s    <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_s    <= r_clk_meta;
      r_clk_prev <= r_clk_s;
      r_dat_meta <= ps2_dat_in;
      r_dat_s    <= r_dat_meta;
    end
  end

  assign w_fe = r_clk_prev & ~r_clk_s;

  // The timeout window opens when CLK is released and covers the
  // bit transfer, the ACK and the wait for idle lines.
  assign w_timed = (r_state == S_SEND) |
                   (r_state == S_ACK) |
                   (r_state == S_WAIT_IDLE);
  assign w_tmo_hit = w_timed & (r_tmo == TMO_LAST);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      rx_inhibit <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (w_tmo_hit) begin
        // Timeout beats a falling edge seen in the same cycle.
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_error   <= 1'b1;
        err_code   <= 2'b01;
        tx_ready   <= 1'b1;
        rx_inhibit <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        if (w_timed) r_tmo <= r_tmo + 1'b1;
        unique case (r_state)
          S_IDLE: begin
            if (tx_valid) begin
              r_shift    <= tx_data;
              r_parity   <= ~^tx_data;
              r_bit_cnt  <= '0;
              r_cnt      <= '0;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              tx_ready   <= 1'b0;
              rx_inhibit <= 1'b1;
              r_state    <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
              r_cnt      <= '0;
              ps2_dat_oe <= 1'b1;
              r_state    <= S_RTS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RTS: begin
            ps2_clk_oe <= 1'b0;
            r_tmo      <= '0;
            r_state    <= S_SEND;
          end
          S_SEND: begin
            if (w_fe) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              // Old count 0..7 selects data bit, 8 parity, 9 stop.
              if (r_bit_cnt < 4'd8) begin
                ps2_dat_oe <= ~r_shift[r_bit_cnt[2:0]];
              end else if (r_bit_cnt == 4'd8) begin
                ps2_dat_oe <= ~r_parity;
              end else begin
                ps2_dat_oe <= 1'b0;
                r_state    <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (w_fe) begin
              if (!r_dat_s) begin
                r_cnt   <= '0;
                r_state <= S_WAIT_IDLE;
              end else begin
                tx_error   <= 1'b1;
                err_code   <= 2'b10;
                tx_ready   <= 1'b1;
                rx_inhibit <= 1'b0;
                r_state    <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (r_clk_s & r_dat_s) begin
              if (r_cnt == IDL_LAST) begin
                tx_done    <= 1'b1;
                tx_ready   <= 1'b1;
                rx_inhibit <= 1'b0;
                r_state    <= S_IDLE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model.
// Short timing parameters keep the run small.
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TMO = 3000;
  localparam int IDL = 25;
  localparam int H   = 20;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       rx_inhibit;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic clk_oe_prev = 1'b0;
  logic frame_ok;
  int fb;
  int n;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES  (INH),
    .TIMEOUT_CYCLES  (TMO),
    .IDLE_WAIT_CYCLES(IDL)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_inhibit(rx_inhibit),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .err_code  (err_code)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) begin
    clk_oe_prev <= ps2_clk_oe;
    if (ps2_clk_oe && !clk_oe_prev) frames <= frames + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    int k;
    frame_ok = 1'b1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk50); #1;
    tx_valid = 1'b0;
    chk1("accept_ready", tx_ready, 1'b0);
    chk1("accept_inhibit", rx_inhibit, 1'b1);
    k = 0;
    while (ps2_clk_oe && !ps2_dat_oe && k < INH + 10) begin
      k++;
      @(posedge clk50); #1;
    end
    chkn("inhibit_len", k, INH);
    chk1("rts_clk_oe", ps2_clk_oe, 1'b1);
    chk1("rts_dat_oe", ps2_dat_oe, 1'b1);
    @(posedge clk50); #1;
    chk1("release_clk_oe", ps2_clk_oe, 1'b0);
    chk1("start_bit_oe", ps2_dat_oe, 1'b1);
  endtask

  task automatic dev_clock(input logic [8:0] exp9, input logic ack,
                           input int abort_edge, input logic spam);
    repeat (H) @(posedge clk50);
    #1;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (spam) begin
        tx_valid = ~tx_valid;
        tx_data  = 8'h00;
      end
      repeat (H) @(posedge clk50);
      #1;
      dev_clk = 1'b1;
      repeat (H) @(posedge clk50);
      #1;
      frame_ok = frame_ok & rx_inhibit & !tx_ready;
      if (k <= 9)
        chk1($sformatf("bit%0d", k), !ps2_dat_oe, exp9[k-1]);
      else
        chk1("stop_released", ps2_dat_oe, 1'b0);
      if (k == abort_edge) return;
    end
    if (spam) tx_valid = 1'b1;
    if (!ack) begin
      dev_clk = 1'b0;
      return;
    end
    dev_dat = 1'b0;
    repeat (2) @(posedge clk50);
    #1;
    dev_clk = 1'b0;
    repeat (H) @(posedge clk50);
    #1;
    dev_clk = 1'b1;
    repeat (H) @(posedge clk50);
    #1;
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input logic spam);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    while (k < 1000 && !seen) begin
      @(posedge clk50); #1;
      k++;
      seen = tx_done;
    end
    if (spam) tx_valid = 1'b0;
    chk1("done_seen", seen, 1'b1);
    chk1("done_ready", tx_ready, 1'b1);
    chk1("done_no_error", tx_error, 1'b0);
    chk1("done_inhibit_low", rx_inhibit, 1'b0);
    chk1("done_lines_free", ps2_clk_oe | ps2_dat_oe, 1'b0);
    chk1("frame_inhibit_held", frame_ok, 1'b1);
    @(posedge clk50); #1;
    chk1("done_one_cycle", tx_done, 1'b0);
  endtask

  task automatic wait_error(input logic [1:0] code);
    int k;
    logic seen;
    k = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      @(posedge clk50); #1;
      k++;
      seen = tx_error;
    end
    chk1("error_seen", seen, 1'b1);
    chk2("error_code", err_code, code);
    chk1("error_lines_free", ps2_clk_oe | ps2_dat_oe, 1'b0);
    chk1("error_ready", tx_ready, 1'b1);
    chk1("error_no_done", tx_done, 1'b0);
    @(posedge clk50); #1;
    chk1("error_one_cycle", tx_error, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    chk1("rst_ready", tx_ready, 1'b1);
    chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("rst_dat_oe", ps2_dat_oe, 1'b0);
    chk1("rst_inhibit", rx_inhibit, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_error", tx_error, 1'b0);
    chk2("rst_err_code", err_code, 2'b00);
    reset = 1'b0;
    repeat (5) @(posedge clk50);
    #1;

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1
    start_frame(8'hED);
    dev_clock(9'b1_1110_1101, 1'b1, 0, 1'b0);
    wait_done(1'b0);

    // 0xF4 with tx_valid toggled throughout: one frame only
    fb = frames;
    start_frame(8'hF4);
    dev_clock(9'b0_1111_0100, 1'b1, 0, 1'b1);
    wait_done(1'b1);
    repeat (5) @(posedge clk50);
    #1;
    chkn("single_frame", frames, fb + 1);
    chk1("no_restart", ps2_clk_oe, 1'b0);

    // 0xFF, device never ACKs
    start_frame(8'hFF);
    dev_clock(9'b1_1111_1111, 1'b0, 0, 1'b0);
    wait_error(2'b10);
    dev_clk = 1'b1;
    repeat (10) @(posedge clk50);
    #1;

    // err_code holds across a successful frame
    start_frame(8'hED);
    dev_clock(9'b1_1110_1101, 1'b1, 0, 1'b0);
    wait_done(1'b0);
    chk2("err_code_held", err_code, 2'b10);

    // device never clocks: timeout measured from CLK release
    start_frame(8'hAA);
    n = 0;
    while (!tx_error && n < TMO + 10) begin
      @(posedge clk50); #1;
      n++;
    end
    chkn("timeout_len", n, TMO);
    chk2("timeout_code", err_code, 2'b01);
    chk1("timeout_lines", ps2_clk_oe | ps2_dat_oe, 1'b0);
    chk1("timeout_ready", tx_ready, 1'b1);
    repeat (5) @(posedge clk50);
    #1;

    // async reset after edge 5 of 0xED (start of a 0 bit)
    start_frame(8'hED);
    dev_clock(9'b1_1110_1101, 1'b1, 5, 1'b0);
    #3;
    reset = 1'b1;
    #2;
    chk1("arst_clk_oe", ps2_clk_oe, 1'b0);
    chk1("arst_dat_oe", ps2_dat_oe, 1'b0);
    chk1("arst_ready", tx_ready, 1'b1);
    chk1("arst_inhibit", rx_inhibit, 1'b0);
    chk2("arst_err_code", err_code, 2'b00);
    @(posedge clk50);
    #1;
    reset = 1'b0;
    dev_clk = 1'b1;
    repeat (10) @(posedge clk50);
    #1;

    start_frame(8'hED);
    dev_clock(9'b1_1110_1101, 1'b1, 0, 1'b0);
    wait_done(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
